// File: rtl/alu_cmd_sequencer.sv
// Command sequencer that drives a combinational ALU from registered operands.
// Reads operands from a small register file and returns each result over valid/ready.
module alu_cmd_sequencer #(
    parameter int BIT = 4,
    parameter int OPCODE = 4,
    parameter int REGS = 4,
    parameter int CNT_W = 8,
    localparam int RW = $clog2(REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [OPCODE-1:0] cmd_op,
    input  logic [RW-1:0]     cmd_dst,
    input  logic [RW-1:0]     cmd_srca,
    input  logic [RW-1:0]     cmd_srcb,
    input  logic [BIT-1:0]    cmd_imm,
    output logic [OPCODE-1:0] alu_instr,
    output logic [BIT-1:0]    alu_a,
    output logic [BIT-1:0]    alu_b,
    input  logic [BIT-1:0]    alu_c,
    input  logic              alu_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BIT-1:0]    res_data,
    output logic              res_flag,
    output logic              carry,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [BIT-1:0] rf [REGS];
    logic [RW-1:0]  dst_q;
    logic           load_q;
    logic [BIT-1:0] imm_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured at accept; the rf write lands at the end of EXEC.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) rf[i] <= '0;
            carry     <= 1'b0;
            res_data  <= '0;
            res_flag  <= 1'b0;
            op_count  <= '0;
            alu_instr <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            dst_q     <= '0;
            load_q    <= 1'b0;
            imm_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= rf[cmd_srca];
                        alu_b     <= rf[cmd_srcb];
                        alu_instr <= cmd_load ? '0 : cmd_op;
                        dst_q     <= cmd_dst;
                        load_q    <= cmd_load;
                        imm_q     <= cmd_imm;
                    end
                end
                EXEC: begin
                    if (load_q) begin
                        rf[dst_q] <= imm_q;
                        res_data  <= imm_q;
                        res_flag  <= 1'b0;
                    end else if (alu_instr != '0) begin
                        rf[dst_q] <= alu_c;
                        carry     <= alu_flag;
                        res_data  <= alu_c;
                        res_flag  <= alu_flag;
                    end else begin
                        res_data  <= '0;
                        res_flag  <= 1'b0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        op_count  <= op_count + CNT_W'(1);
                        alu_instr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
// Each test task drives one scenario and checks hand-computed values inline.
module tb_alu_cmd_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [3:0] cmd_op = '0;
    logic [1:0] cmd_dst = '0;
    logic [1:0] cmd_srca = '0;
    logic [1:0] cmd_srcb = '0;
    logic [3:0] cmd_imm = '0;
    logic [3:0] alu_instr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_c;
    logic       alu_flag;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_flag;
    logic       carry;
    logic       busy;
    logic [7:0] op_count;

    int checks = 0;
    int fails = 0;
    logic [3:0] got_d;
    logic       got_f;

    always #5 clock = ~clock;

    alu_cmd_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
        .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_flag(alu_flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag),
        .carry(carry), .busy(busy), .op_count(op_count)
    );

    // Reference ALU: ADD/SUB report carry/borrow, NOT clears flag, others give 0/0.
    logic [4:0] wide;
    always_comb begin
        wide     = '0;
        alu_c    = '0;
        alu_flag = 1'b0;
        case (alu_instr)
            4'b1011: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b};
                {alu_flag, alu_c} = wide;
            end
            4'b1100: begin
                wide = {1'b0, alu_a} - {1'b0, alu_b};
                {alu_flag, alu_c} = wide;
            end
            4'b0001: alu_c = ~alu_a;
            default: ;
        endcase
    end

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic accept_cmd(input logic ld, input logic [3:0] op,
                              input logic [1:0] d, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [3:0] imm);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_load = ld;
        cmd_op = op;
        cmd_dst = d;
        cmd_srca = sa;
        cmd_srcb = sb;
        cmd_imm = imm;
        while (!cmd_ready && n < 20) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd();
        int n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            fails++;
            $display("FAIL result_timeout: res_valid=%b required 1", res_valid);
        end
        got_d = res_data;
        got_f = res_flag;
        res_ready = 1'b1;
        @(posedge clock);
        #1 res_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic ld, input logic [3:0] op,
                           input logic [1:0] d, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [3:0] imm);
        accept_cmd(ld, op, d, sa, sb, imm);
        finish_cmd();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_ready, res_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL reset_hs: rdy/val/busy=%b required 100",
                     {cmd_ready, res_valid, busy});
        end
        checks++;
        if (alu_instr !== 4'b0000 || alu_a !== 4'h0 || alu_b !== 4'h0) begin
            fails++;
            $display("FAIL reset_alu: instr=%h a=%h b=%h required 0 0 0",
                     alu_instr, alu_a, alu_b);
        end
        checks++;
        if (carry !== 1'b0 || op_count !== 8'd0 || res_data !== 4'h0 || res_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs: carry=%b cnt=%0d data=%h flag=%b required 0 0 0 0",
                     carry, op_count, res_data, res_flag);
        end
        for (int i = 0; i < 4; i++) begin
            accept_cmd(1'b0, 4'b0000, 2'(i), 2'(i), 2'(i), 4'h0);
            checks++;
            if (alu_a !== 4'h0 || alu_b !== 4'h0) begin
                fails++;
                $display("FAIL reset_rf%0d: a=%h b=%h required 0 0", i, alu_a, alu_b);
            end
            finish_cmd();
        end
    endtask

    task automatic test_add();
        do_reset();
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h9);
        checks++;
        if (got_d !== 4'h9 || got_f !== 1'b0) begin
            fails++;
            $display("FAIL load_result: data=%h flag=%b required 9 0", got_d, got_f);
        end
        run_cmd(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h8);
        accept_cmd(1'b0, 4'b1011, 2'd2, 2'd0, 2'd1, 4'h0);
        checks++;
        if (alu_a !== 4'h9 || alu_b !== 4'h8 || alu_instr !== 4'b1011) begin
            fails++;
            $display("FAIL add_exec: a=%h b=%h instr=%h required 9 8 b",
                     alu_a, alu_b, alu_instr);
        end
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL add_exec_hs: val=%b busy=%b rdy=%b required 0 1 0",
                     res_valid, busy, cmd_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 4'h1 || res_flag !== 1'b1 || carry !== 1'b1) begin
            fails++;
            $display("FAIL add_done: val=%b data=%h flag=%b carry=%b required 1 1 1 1",
                     res_valid, res_data, res_flag, carry);
        end
        finish_cmd();
        checks++;
        if (op_count !== 8'd3) begin
            fails++;
            $display("FAIL add_count: op_count=%0d required 3", op_count);
        end
        accept_cmd(1'b0, 4'b0000, 2'd3, 2'd2, 2'd2, 4'h0);
        checks++;
        if (alu_a !== 4'h1) begin
            fails++;
            $display("FAIL add_rf2: rf2=%h required 1", alu_a);
        end
        finish_cmd();
    endtask

    task automatic test_sub_not();
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h3);
        run_cmd(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h5);
        run_cmd(1'b0, 4'b1100, 2'd0, 2'd0, 2'd1, 4'h0);
        checks++;
        if (got_d !== 4'hE || got_f !== 1'b1) begin
            fails++;
            $display("FAIL sub_result: data=%h flag=%b required e 1", got_d, got_f);
        end
        accept_cmd(1'b0, 4'b0001, 2'd0, 2'd0, 2'd0, 4'h0);
        checks++;
        if (alu_a !== 4'hE) begin
            fails++;
            $display("FAIL sub_rf0: rf0=%h required e", alu_a);
        end
        finish_cmd();
        checks++;
        if (got_d !== 4'h1 || got_f !== 1'b0 || carry !== 1'b0) begin
            fails++;
            $display("FAIL not_result: data=%h flag=%b carry=%b required 1 0 0",
                     got_d, got_f, carry);
        end
        checks++;
        if (op_count !== 8'd8) begin
            fails++;
            $display("FAIL sub_count: op_count=%0d required 8", op_count);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h9);
        run_cmd(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h8);
        accept_cmd(1'b0, 4'b1011, 2'd3, 2'd0, 2'd1, 4'h0);
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd_load = 1'b1;
        cmd_dst = 2'd2;
        cmd_imm = 4'h7;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== 4'h1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL stall_%0d: val=%b data=%h rdy=%b busy=%b required 1 1 0 1",
                         i, res_valid, res_data, cmd_ready, busy);
            end
            @(posedge clock);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clock);
        #1 res_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd11) begin
            fails++;
            $display("FAIL release_idle: rdy=%b val=%b busy=%b cnt=%0d required 1 0 0 11",
                     cmd_ready, res_valid, busy, op_count);
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL pending_accept: busy=%b rdy=%b required 1 0", busy, cmd_ready);
        end
        finish_cmd();
        checks++;
        if (got_d !== 4'h7 || got_f !== 1'b0 || op_count !== 8'd12) begin
            fails++;
            $display("FAIL pending_result: data=%h flag=%b cnt=%0d required 7 0 12",
                     got_d, got_f, op_count);
        end
    endtask

    task automatic test_nop_unlisted();
        checks++;
        if (carry !== 1'b1) begin
            fails++;
            $display("FAIL nop_pre_carry: carry=%b required 1", carry);
        end
        run_cmd(1'b0, 4'b0000, 2'd2, 2'd0, 2'd1, 4'h0);
        checks++;
        if (got_d !== 4'h0 || got_f !== 1'b0 || carry !== 1'b1 || op_count !== 8'd13) begin
            fails++;
            $display("FAIL nop_result: data=%h flag=%b carry=%b cnt=%0d required 0 0 1 13",
                     got_d, got_f, carry, op_count);
        end
        accept_cmd(1'b0, 4'b0000, 2'd0, 2'd2, 2'd2, 4'h0);
        checks++;
        if (alu_a !== 4'h7) begin
            fails++;
            $display("FAIL nop_rf2: rf2=%h required 7", alu_a);
        end
        finish_cmd();
        run_cmd(1'b0, 4'b1111, 2'd3, 2'd0, 2'd1, 4'h0);
        checks++;
        if (got_d !== 4'h0 || got_f !== 1'b0 || carry !== 1'b0) begin
            fails++;
            $display("FAIL unlisted_result: data=%h flag=%b carry=%b required 0 0 0",
                     got_d, got_f, carry);
        end
        accept_cmd(1'b0, 4'b0000, 2'd0, 2'd3, 2'd3, 4'h0);
        checks++;
        if (alu_a !== 4'h0) begin
            fails++;
            $display("FAIL unlisted_rf3: rf3=%h required 0", alu_a);
        end
        finish_cmd();
        checks++;
        if (op_count !== 8'd16) begin
            fails++;
            $display("FAIL nop_count: op_count=%0d required 16", op_count);
        end
    endtask

    task automatic test_reset_exec();
        logic seen = 1'b0;
        run_cmd(1'b0, 4'b1011, 2'd2, 2'd0, 2'd1, 4'h0);
        accept_cmd(1'b0, 4'b1011, 2'd2, 2'd0, 2'd1, 4'h0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || carry !== 1'b0 || op_count !== 8'd0) begin
            fails++;
            $display("FAIL exec_reset: busy=%b rdy=%b carry=%b cnt=%0d required 0 1 0 0",
                     busy, cmd_ready, carry, op_count);
        end
        for (int i = 0; i < 4; i++) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL exec_reset_valid: res_valid seen=%b required 0", seen);
        end
        for (int i = 0; i < 3; i++) begin
            accept_cmd(1'b0, 4'b0000, 2'd3, 2'(i), 2'(i), 4'h0);
            checks++;
            if (alu_a !== 4'h0) begin
                fails++;
                $display("FAIL exec_reset_rf%0d: rf=%h required 0", i, alu_a);
            end
            finish_cmd();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_not();
        test_back_to_back();
        test_nop_unlisted();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
